prog_loader: RTL
================

Name: prog_loader

Overview:
- Writer side of the instruction store: receives a framed byte stream, packs it into 32-bit instruction words, and writes them sequentially into the program-memory write port.
- Holds the processor in `cpu_hold` until a complete, checksum-verified image has been loaded.
- Sits between an external byte source (UART or testbench) and the instruction memory. The processor only reads that memory.

Parameters:
- ADDR_W, 5, instruction-memory address width; DEPTH = 2**ADDR_W words (32 by default).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  a byte is offered on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte; a transfer occurs when in_valid && in_ready.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  instruction word.
- cpu_hold  out  1  keeps the processor stalled/in reset while high.
- done  out  1  image loaded and verified.
- error  out  1  frame rejected.

Behaviour:
- Frame format, in order:
  - COUNT byte N, legal range 1..DEPTH.
  - N words, 4 bytes each, MSB first.
  - CHECK byte = XOR of every preceding byte, COUNT included.
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, error=0, cpu_hold=1; internal counters and the running XOR are cleared.
- States: IDLE, COUNT, DATA, CHECK, DONE, ERR.
- in_ready=1 only in COUNT, DATA and CHECK; 0 in all other states. Bytes offered while in_ready=0 are dropped, not buffered.
- IDLE:
  - start -> COUNT.
  - Entering COUNT clears the running XOR, byte index, word address and words-written counter.
- COUNT, on transfer:
  - XOR the byte in.
  - N==0 or N>DEPTH -> ERR.
  - Otherwise latch N and go to DATA.
- DATA, on each transfer:
  - Shift the byte into the word register, first byte landing in bits [31:24].
  - XOR the byte in and increment the 2-bit byte index.
- DATA, on the 4th byte of a word:
  - Exactly one cycle later: imem_we=1, imem_addr=current word address, imem_wdata=packed word.
  - Address and words-written counter increment in that same cycle.
  - Write latency is 1 cycle after the accepting edge.
- in_ready stays high during the write cycle. The next word's first byte may be accepted concurrently; throughput is 1 byte/cycle with no stall.
- After the Nth write -> CHECK. imem_addr never wraps: the maximum address DEPTH-1 is reached only when N==DEPTH.
- CHECK, on transfer:
  - byte == running XOR -> DONE.
  - Otherwise -> ERR.
- DONE: done=1, cpu_hold=0, in_ready=0.
- ERR: error=1, cpu_hold=1, in_ready=0. Words already written are not rolled back.
- start in DONE or ERR:
  - Clears done and error, sets cpu_hold=1, enters COUNT next cycle.
  - start in COUNT, DATA or CHECK is ignored.
- rst at any time, including mid-word or during a write cycle:
  - Next state is IDLE with the reset output values.
  - A pending write is cancelled (imem_we=0).
  - Memory contents are left as they are.
- Simultaneous rst and start: rst wins.
- imem_we is never asserted outside DATA-completion cycles.

Decomposition:
- Shared package `prog_loader_pkg`:
  - State enum (IDLE, COUNT, DATA, CHECK, DONE, ERR).
  - BYTES_PER_WORD = 4.
  - CHK_SEED = 8'h00.
- One natural sub-module, `byte_word_packer`:
  - Inputs: byte-valid and byte.
  - Holds the 2-bit index and the 32-bit shift register.
  - Emits a 1-cycle word_valid plus word.
  - Synchronous clear input.
- The FSM, address counter and checksum stay in prog_loader.

Test Plan:
- Two-word load: start; bytes 02, 20 08 00 04, 20 09 00 0F, 08 -> writes addr0=0x20080004, addr1=0x2009000F; then done=1, cpu_hold=0, error=0.
- Bad checksum: same frame with last byte 09 -> both writes still occur; error=1, done=0, cpu_hold=1.
- Illegal count: COUNT 00 -> ERR, no imem_we. Restart with COUNT 0x21 (33 > DEPTH) -> ERR again.
- Gappy source: the two-word frame with in_valid low for 0-3 random cycles between bytes, plus in_valid pulses while in IDLE -> identical writes and done; IDLE bytes ignored.
- Reset mid-load: rst after 6 data bytes -> IDLE next cycle, cpu_hold=1, no further writes. A fresh start with the full frame then completes normally.
- Full image: N=0x20, 32 words with value = address, correct XOR -> 32 back-to-back writes at addr 0..31, no wrap, done=1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, word
// geometry and checksum seed.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [7:0] CHK_SEED       = 8'h00;

endpackage

// File: rtl/byte_word_packer.sv
// Packs bytes MSB-first into 32-bit words; presents each completed word with
// a one-cycle valid strobe in the cycle after its last byte is accepted.
module byte_word_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_last,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_idx;
  logic [31:0] r_shift;
  logic [31:0] r_word;
  logic        r_word_valid;
  logic [31:0] w_shift_next;

  assign w_shift_next = {r_shift[23:0], i_byte};
  assign o_last       = (r_idx == 2'(BYTES_PER_WORD - 1));
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

  // Output word is captured separately so the shifter can start on the next
  // word while this one is still being written.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_idx        <= 2'd0;
      r_shift      <= 32'd0;
      r_word       <= 32'd0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_valid) begin
        r_shift <= w_shift_next;
        r_idx   <= r_idx + 2'd1;
        if (o_last) begin
          r_word       <= w_shift_next;
          r_word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader for the instruction memory: COUNT, N packed
// words, XOR CHECK byte; releases cpu_hold only after a verified image.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_done;
  logic              r_error;
  logic              r_hold;
  logic [7:0]        r_xor;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W:0]   r_words;
  logic [ADDR_W-1:0] r_addr;

  logic              w_xfer;
  logic              w_start_ok;
  logic              w_pack_valid;
  logic              w_last;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic              w_count_bad;

  assign w_xfer       = in_valid && r_in_ready;
  assign w_start_ok   = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_pack_valid = w_xfer && (r_state == DATA);
  assign w_count_bad  = (in_data == 8'd0) || ({24'd0, in_data} > 32'(DEPTH));

  byte_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_start_ok),
    .i_valid      (w_pack_valid),
    .i_byte       (in_data),
    .o_last       (w_last),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  assign in_ready   = r_in_ready;
  assign imem_we    = w_word_valid;
  assign imem_addr  = r_addr;
  assign imem_wdata = w_word;
  assign cpu_hold   = r_hold;
  assign done       = r_done;
  assign error      = r_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_hold     <= 1'b1;
      r_xor      <= CHK_SEED;
      r_n        <= '0;
      r_words    <= '0;
      r_addr     <= '0;
    end else begin
      if (w_word_valid)
        r_addr <= r_addr + 1'b1;
      case (r_state)
        IDLE, DONE, ERR: begin
          if (start) begin
            r_state    <= COUNT;
            r_in_ready <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_hold     <= 1'b1;
            r_xor      <= CHK_SEED;
            r_words    <= '0;
            r_addr     <= '0;
          end
        end
        COUNT: begin
          if (w_xfer) begin
            r_xor <= r_xor ^ in_data;
            if (w_count_bad) begin
              r_state    <= ERR;
              r_in_ready <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_n     <= (ADDR_W + 1)'(in_data);
              r_state <= DATA;
            end
          end
        end
        // Leave DATA as the last byte of the last word is accepted, so the
        // CHECK byte can land during that word's write cycle.
        DATA: begin
          if (w_xfer) begin
            r_xor <= r_xor ^ in_data;
            if (w_last) begin
              r_words <= r_words + 1'b1;
              if (r_words == r_n - 1'b1)
                r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (w_xfer) begin
            r_in_ready <= 1'b0;
            if (in_data == r_xor) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else begin
              r_state <= ERR;
              r_error <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
